// File: rtl/xc_aes_pkg.sv
// Shared AES constants, byte type and GF(2^8) helpers for the XCrypto AES units.
// Used by xc_aessub (SubBytes/InvSubBytes) and the MixColumns unit (xtime).
package xc_aes_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] aes_byte_t;

  localparam aes_byte_t AFFINE_C     = 8'h63;
  localparam aes_byte_t INV_AFFINE_C = 8'h05;
  localparam aes_byte_t GF_POLY      = 8'h1b;

  // Position of the shared S-box in the area-optimised variant; value == byte index.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY1 = 2'd1,
    ST_BUSY2 = 2'd2,
    ST_DONE  = 2'd3
  } cnt_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? GF_POLY : 8'h00);
  endfunction

  // Shift-and-add GF(2^8) multiply.
  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t p;
    aes_byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < BYTE_W; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Rotate a byte left by n (1..7).
  function automatic aes_byte_t rotl8(input aes_byte_t b, input int unsigned n);
    return aes_byte_t'((b << n) | (b >> (BYTE_W - n)));
  endfunction

endpackage

// File: rtl/xc_aessub_sbox.sv
// Single combinational AES byte S-box: GF(2^8) inverse plus affine transform.
// Ports: din  - input byte
//        enc  - 1 = forward S-box, 0 = inverse S-box
//        dout - substituted byte
// Macro XC_AESSUB_INVERSE_EN: when undefined the inverse path is compiled out
// and enc is ignored (forward S-box only).
module xc_aessub_sbox
  import xc_aes_pkg::*;
(
  input  logic [7:0] din,
  input  logic       enc,
  output logic [7:0] dout
);

  // x^254 == x^-1 (and maps 0 to 0) via square-and-multiply.
  function automatic aes_byte_t gf_inv(input aes_byte_t x);
    aes_byte_t sq;
    aes_byte_t acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic aes_byte_t fwd_affine(input aes_byte_t b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ AFFINE_C;
  endfunction

`ifdef XC_AESSUB_INVERSE_EN
  function automatic aes_byte_t inv_affine(input aes_byte_t b);
    return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ INV_AFFINE_C;
  endfunction

  aes_byte_t inv_in;
  aes_byte_t inv_out;

  // One GF inverse shared by both directions; affine sits before or after it.
  assign inv_in  = enc ? din : inv_affine(din);
  assign inv_out = gf_inv(inv_in);
  assign dout    = enc ? fwd_affine(inv_out) : inv_out;
`else
  logic unused_enc;
  assign unused_enc = enc;
  assign dout       = fwd_affine(gf_inv(din));
`endif

endmodule

// File: rtl/xc_aessub.sv
// AES SubBytes / InvSubBytes instruction unit (feeds MixColumns).
// Ports: clock, reset (sync, active-low), flush (core's valid && ready),
//        valid, rs1 (t0=[7:0], t1=[15:8]), rs2 (t2=[23:16], t3=[31:24]),
//        enc (1 = forward S-box), rot (rotate result bytes),
//        ready (result valid this cycle), result (substituted word).
// FAST=1: four S-boxes, combinational, ready = valid.
// FAST=0: one shared S-box over four cycles, ready in the 4th valid cycle.
// Macro XC_AESSUB_INVERSE_EN enables the inverse S-box; undefined forces forward.
module xc_aessub
  import xc_aes_pkg::*;
#(
  parameter bit FAST = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  input  logic        rot,
  output logic        ready,
  output logic [31:0] result
);

  localparam int unsigned NBYTES = 4;
  localparam int unsigned ACC_W  = 24;

  aes_byte_t t_byte [NBYTES];
  aes_byte_t s_byte [NBYTES];

  assign t_byte[0] = rs1[7:0];
  assign t_byte[1] = rs1[15:8];
  assign t_byte[2] = rs2[23:16];
  assign t_byte[3] = rs2[31:24];

  logic unused_bits;
  assign unused_bits = ^{rs1[31:16], rs2[15:0]};

  generate
    if (FAST) begin : g_fast
      // Stateless variant: clock, reset and flush have no effect.
      logic unused_ctrl;
      assign unused_ctrl = ^{clock, reset, flush};

      for (genvar i = 0; i < NBYTES; i++) begin : g_sbox
        xc_aessub_sbox u_sbox (
          .din  (t_byte[i]),
          .enc  (enc),
          .dout (s_byte[i])
        );
      end

      assign ready = valid;
    end else begin : g_small
      cnt_e             cnt_q;
      cnt_e             cnt_d;
      logic [ACC_W-1:0] acc_q;
      logic [ACC_W-1:0] acc_d;
      aes_byte_t        sel;
      aes_byte_t        sub;

      xc_aessub_sbox u_sbox (
        .din  (sel),
        .enc  (enc),
        .dout (sub)
      );

      // Byte fed to the shared S-box is chosen by the counter.
      always_comb begin
        sel = t_byte[0];
        case (cnt_q)
          ST_IDLE:  sel = t_byte[0];
          ST_BUSY1: sel = t_byte[1];
          ST_BUSY2: sel = t_byte[2];
          default:  sel = t_byte[3];
        endcase
      end

      // State register; reset wins over flush and advance.
      always_ff @(posedge clock) begin
        if (!reset) begin
          cnt_q <= ST_IDLE;
          acc_q <= '0;
        end else begin
          cnt_q <= cnt_d;
          acc_q <= acc_d;
        end
      end

      // Next state and handshake; flush only rewinds cnt, acc bytes get rewritten anyway.
      always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        ready = valid && (cnt_q == ST_DONE);
        if (flush) begin
          cnt_d = ST_IDLE;
        end else if (valid) begin
          case (cnt_q)
            ST_IDLE: begin
              acc_d[7:0] = sub;
              cnt_d      = ST_BUSY1;
            end
            ST_BUSY1: begin
              acc_d[15:8] = sub;
              cnt_d       = ST_BUSY2;
            end
            ST_BUSY2: begin
              acc_d[23:16] = sub;
              cnt_d        = ST_DONE;
            end
            default: cnt_d = ST_DONE;
          endcase
        end
      end

      // t3 is substituted live in the DONE cycle.
      assign s_byte[0] = acc_q[7:0];
      assign s_byte[1] = acc_q[15:8];
      assign s_byte[2] = acc_q[23:16];
      assign s_byte[3] = sub;
    end
  endgenerate

  assign result = rot ? {s_byte[2], s_byte[1], s_byte[0], s_byte[3]}
                      : {s_byte[3], s_byte[2], s_byte[1], s_byte[0]};

endmodule

// File: tb/tb_xc_aessub.sv
// Scoreboard bench for xc_aessub: one FAST=1 and one FAST=0 instance, random and
// directed instructions checked against table-driven S-box reference tables.
module tb_xc_aessub;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] cyc;
  } exp_t;

  logic        clock;
  logic        reset;

  logic        valid_f, enc_f, rot_f, ready_f, flush_f;
  logic [31:0] rs1_f, rs2_f, result_f;

  logic        valid_s, enc_s, rot_s, ready_s, flush_s, force_flush;
  logic [31:0] rs1_s, rs2_s, result_s;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] cyc      = 32'd0;

  logic [31:0] q_f [$];
  exp_t        q_s [$];

  logic [7:0]  fwd_tab [256];
  logic [7:0]  inv_tab [256];

  assign flush_f = valid_f & ready_f;
  assign flush_s = (valid_s & ready_s) | force_flush;

  xc_aessub #(.FAST(1'b1)) u_fast (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush_f),
    .valid  (valid_f),
    .rs1    (rs1_f),
    .rs2    (rs2_f),
    .enc    (enc_f),
    .rot    (rot_f),
    .ready  (ready_f),
    .result (result_f)
  );

  xc_aessub #(.FAST(1'b0)) u_slow (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush_s),
    .valid  (valid_s),
    .rs1    (rs1_s),
    .rs2    (rs2_s),
    .enc    (enc_s),
    .rot    (rot_s),
    .ready  (ready_s),
    .result (result_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 32'd1;

  // Reference model: S-box from its mathematical definition.
  function automatic int gmul(input int a_in, input int b);
    int p;
    int a;
    p = 0;
    a = a_in;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a << 1;
      if ((a & 'h100) != 0) a = a ^ 'h11b;
    end
    return p;
  endfunction

  task automatic build_tables();
    int         inv;
    logic [7:0] b;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(x, y) == 1) inv = y;
      b = 8'(inv);
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
      fwd_tab[x] = s;
    end
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
  endtask

  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b,
                                          input logic e, input logic r);
    logic [7:0] t [4];
    logic [7:0] s [4];
    logic       fwd;
`ifdef XC_AESSUB_INVERSE_EN
    fwd = e;
`else
    fwd = e | 1'b1;
`endif
    t[0] = a[7:0];
    t[1] = a[15:8];
    t[2] = b[23:16];
    t[3] = b[31:24];
    for (int i = 0; i < 4; i++) s[i] = fwd ? fwd_tab[t[i]] : inv_tab[t[i]];
    return r ? {s[2], s[1], s[0], s[3]} : {s[3], s[2], s[1], s[0]};
  endfunction

  // Monitor: pops and compares whenever a DUT presents a result.
  exp_t        mon_e;
  logic [31:0] mon_f;
  always @(negedge clock) begin
    checks++;
    if (ready_f !== valid_f) begin
      failures++;
      $display("FAIL fast_ready got=%0b exp=%0b", ready_f, valid_f);
    end
    if (valid_f && ready_f) begin
      checks++;
      if (q_f.size() == 0) begin
        failures++;
        $display("FAIL fast_unexpected got=%08h exp=none", result_f);
      end else begin
        mon_f = q_f.pop_front();
        if (result_f !== mon_f) begin
          failures++;
          $display("FAIL fast_result got=%08h exp=%08h", result_f, mon_f);
        end
      end
    end
    if (!valid_s) begin
      checks++;
      if (ready_s !== 1'b0) begin
        failures++;
        $display("FAIL slow_idle_ready got=%0b exp=0", ready_s);
      end
    end else if (ready_s === 1'b1) begin
      checks++;
      if (q_s.size() == 0) begin
        failures++;
        $display("FAIL slow_unexpected got=%08h exp=none", result_s);
      end else begin
        mon_e = q_s.pop_front();
        if (result_s !== mon_e.res) begin
          failures++;
          $display("FAIL slow_result got=%08h exp=%08h", result_s, mon_e.res);
        end
        checks++;
        if ((cyc - mon_e.cyc) != 32'd3) begin
          failures++;
          $display("FAIL slow_latency got=%0d exp=3", cyc - mon_e.cyc);
        end
      end
    end
  end

  task automatic fast_op(input logic [31:0] a, input logic [31:0] b,
                         input logic e, input logic r, input logic [31:0] exp);
    rs1_f   = a;
    rs2_f   = b;
    enc_f   = e;
    rot_f   = r;
    valid_f = 1'b1;
    q_f.push_back(exp);
    @(posedge clock);
    #1;
  endtask

  // Issues one instruction with valid held; returns just after the completing edge.
  task automatic slow_op(input logic [31:0] a, input logic [31:0] b,
                         input logic e, input logic r, input logic [31:0] exp);
    int   n;
    exp_t x;
    rs1_s   = a;
    rs2_s   = b;
    enc_s   = e;
    rot_s   = r;
    valid_s = 1'b1;
    x.res   = exp;
    x.cyc   = cyc;
    q_s.push_back(x);
    n = 0;
    while (ready_s !== 1'b1 && n < 8) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (ready_s !== 1'b1) begin
      failures++;
      $display("FAIL slow_timeout got=ready0 exp=ready1");
      q_s.delete();
      force_flush = 1'b1;
      @(posedge clock);
      #1;
      force_flush = 1'b0;
    end else begin
      @(posedge clock);
      #1;
    end
  endtask

  logic [31:0] ra, rb;
  logic        re, rr;

  initial begin
    build_tables();
    reset       = 1'b0;
    force_flush = 1'b0;
    valid_f = 1'b0; enc_f = 1'b0; rot_f = 1'b0; rs1_f = '0; rs2_f = '0;
    valid_s = 1'b0; enc_s = 1'b0; rot_s = 1'b0; rs1_s = '0; rs2_s = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (ready_s !== 1'b0 || ready_f !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%0b%0b exp=00", ready_f, ready_s);
    end
    reset = 1'b1;

    // Fast variant: directed vectors then random back-to-back.
    fast_op(32'h00000100, 32'hff530000, 1'b1, 1'b0, 32'h16ed7c63);
    fast_op(32'h00000100, 32'hff530000, 1'b1, 1'b1, 32'hed7c6316);
`ifndef XC_AESSUB_INVERSE_EN
    fast_op(32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h63636363);
`endif
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      re = 1'($urandom_range(0, 1)); rr = 1'($urandom_range(0, 1));
      fast_op(ra, rb, re, rr, ref_sub(ra, rb, re, rr));
    end
    valid_f = 1'b0;
    @(posedge clock);
    #1;

    // Slow variant: directed latency/result.
`ifdef XC_AESSUB_INVERSE_EN
    slow_op(32'h00007c63, 32'h16ed0000, 1'b0, 1'b0, 32'hff530100);
`else
    slow_op(32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h63636363);
`endif
    valid_s = 1'b0;
    @(posedge clock);
    #1;

    // Flush mid-operation, then a fresh instruction.
    rs1_s = $urandom; rs2_s = $urandom; enc_s = 1'b1; rot_s = 1'b0; valid_s = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    force_flush = 1'b1;
    @(posedge clock);
    #1;
    force_flush = 1'b0;
    slow_op(32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h63636363);

    // Reset in cycle 2 of an operation; the restart must show full latency.
    ra = $urandom; rb = $urandom;
    rs1_s = ra; rs2_s = rb; enc_s = 1'b1; rot_s = 1'b1; valid_s = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (ready_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_ready got=%0b exp=0", ready_s);
    end
    reset = 1'b1;
    slow_op(ra, rb, 1'b1, 1'b1, ref_sub(ra, rb, 1'b1, 1'b1));

    // Random back-to-back instructions.
    for (int i = 0; i < 15; i++) begin
      ra = $urandom; rb = $urandom;
      re = 1'($urandom_range(0, 1)); rr = 1'($urandom_range(0, 1));
      slow_op(ra, rb, re, rr, ref_sub(ra, rb, re, rr));
    end
    valid_s = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    checks++;
    if (q_f.size() != 0 || q_s.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d/%0d exp=0/0", q_f.size(), q_s.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xc_aessub.md
Name: xc_aessub

Overview:
- AES SubBytes / InvSubBytes instruction unit.
- Sits directly upstream of the MixColumns unit in the AES round datapath: its result word is the operand that feeds MixColumns on the next instruction.
- Applies the AES S-box (or inverse S-box) to four bytes gathered from two source registers, with an optional rotation.
- Same valid/ready/flush instruction handshake as the other XCrypto functional units; FAST and area-optimised variants are selected by parameter.

Parameters:
- FAST, 1'b1. 1 = four parallel S-boxes, single cycle. 0 = one shared S-box, four cycles.

Ports:
- clock   input   1   Clock; all state updates on rising edge.
- reset   input   1   Synchronous, active-low reset.
- flush   input   1   Discard internal state; driven by the core as valid && ready.
- valid   input   1   Operands valid; held stable with operands until ready.
- rs1     input   32  Source register 1; bytes [7:0]=t0, [15:8]=t1.
- rs2     input   32  Source register 2; bytes [23:16]=t2, [31:24]=t3.
- enc     input   1   1 = forward S-box; 0 = inverse S-box.
- rot     input   1   1 = rotate output bytes.
- ready   output  1   Result valid this cycle.
- result  output  32  Substituted word.

Behaviour:
- Result bytes:
  - rot=0: result = {S(t3),S(t2),S(t1),S(t0)}.
  - rot=1: result = {S(t2),S(t1),S(t0),S(t3)}.
  - S = forward S-box if enc, else inverse S-box.
- FAST=1:
  - Purely combinational; ready = valid, latency 0 cycles.
  - No state; reset and flush have no effect.
- FAST=0:
  - 2-bit counter cnt, 24-bit byte accumulator acc; reset value cnt=0, acc=0.
  - Each cycle with valid && cnt<3: the shared S-box processes byte t[cnt]; result stored to acc[8*cnt +: 8]; cnt++.
  - At cnt==3 && valid: ready=1. t3 is substituted combinationally and result is assembled from acc plus the live byte. cnt does not advance.
  - Latency: ready asserted in the 4th consecutive valid cycle.
  - States are implied by cnt: IDLE (cnt=0), BUSY (cnt 1..2), DONE (cnt=3).
- Flush (FAST=0): next cnt=0; acc is left unchanged, since stale bytes are never exposed before being rewritten.
- Priority: reset over flush over advance.
- valid falling mid-operation without flush: the unit holds cnt. A protocol violation; not required to be meaningful.
- reset low mid-operation: cnt=0 next cycle. ready is 0 while cnt!=3.
- ready is forced 0 whenever valid=0, in both variants.
- Back-to-back instructions: the core asserts flush in the completing cycle, so the next instruction starts from cnt=0 the following cycle.
- Operands and enc/rot must be stable while valid && !ready.

Optional Feature:
- Macro: XC_AESSUB_INVERSE_EN.
- Defined: inverse S-box datapath present; enc selects direction as above.
- Undefined:
  - Inverse affine/selection logic is compiled out.
  - enc is ignored and the forward S-box is always applied.
  - Latency and handshake are unchanged.

Decomposition:
- Shared package xc_aes_pkg:
  - AES affine constant 8'h63 and inverse affine constant 8'h05.
  - GF(2^8) reduction polynomial 8'h1b.
  - Byte typedef.
  - xtime function, shared with the MixColumns unit.
- Sub-module xc_aessub_sbox:
  - One combinational byte S-box: input byte, enc, output byte.
  - Built as GF inverse plus forward/inverse affine transforms.
  - Instantiated 4x when FAST=1, 1x when FAST=0.

Test Plan:
- FAST=1, enc=1, rot=0, rs1=0x00000100, rs2=0xff530000, valid=1 -> same cycle ready=1, result=0x16ed7c63.
- FAST=1, enc=1, rot=1, same operands -> result=0xed7c6316.
- FAST=0, enc=0, rot=0, rs1=0x00007c63, rs2=0x16ed0000, valid held -> ready=0 for 3 cycles, ready=1 in 4th, result=0xff530100.
- FAST=0: start instruction, assert flush after 2 cycles, then new operands rs1=0x00000000, rs2=0x00000000, enc=1 -> ready in 4th cycle, result=0x63636363.
- FAST=0: drive reset=0 in cycle 2 of an operation, release -> ready=0 and cnt=0 after reset; a full fresh 4-cycle latency is then observed.
- Macro undefined, enc=0, rs1=0x00000000, rs2=0x00000000 -> result=0x63636363, identical to enc=1.
